// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, start/8 data/odd parity/stop,
// then ACK sampling on the 11th device clock. Outputs are open-collector enables (1 = pull low).
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int FILTER_STEPS   = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        START,
        DATA,
        STOP,
        WAIT_REL
    } state_t;

    state_t                  r_state, w_state_next;
    logic                    r_ps2d_meta, r_ps2d_sync;
    logic [FILTER_STEPS-1:0] r_filt;
    logic                    r_ps2c_filt, w_ps2c_filt_next, w_fall;
    logic [8:0]              r_sr, w_sr_next;
    logic [3:0]              r_bit_cnt, w_bit_cnt_next;
    logic [IW-1:0]           r_inh_cnt, w_inh_cnt_next;
    logic [TW-1:0]           r_to_cnt, w_to_cnt_next;
    logic                    r_err, w_err_next;
    logic                    w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ps2d_meta <= 1'b1;
            r_ps2d_sync <= 1'b1;
            r_filt      <= '1;
            r_ps2c_filt <= 1'b1;
        end else begin
            r_ps2d_meta <= ps2d;
            r_ps2d_sync <= r_ps2d_meta;
            r_filt      <= {ps2c, r_filt[FILTER_STEPS-1:1]};
            r_ps2c_filt <= w_ps2c_filt_next;
        end
    end

    // Filtered clock only changes on a full run of identical samples, so short glitches hold it.
    always_comb begin
        w_ps2c_filt_next = r_ps2c_filt;
        if (&r_filt)
            w_ps2c_filt_next = 1'b1;
        else if (~|r_filt)
            w_ps2c_filt_next = 1'b0;
        w_fall = r_ps2c_filt & ~w_ps2c_filt_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sr      <= w_sr_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_inh_cnt <= w_inh_cnt_next;
            r_to_cnt  <= w_to_cnt_next;
            r_err     <= w_err_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_sr_next      = r_sr;
        w_bit_cnt_next = r_bit_cnt;
        w_inh_cnt_next = r_inh_cnt;
        w_to_cnt_next  = r_to_cnt + TW'(1);
        w_err_next     = r_err;
        ps2c_oe        = 1'b0;
        ps2d_oe        = 1'b0;
        tx_idle        = 1'b0;
        tx_done        = 1'b0;
        w_timeout      = (r_state != IDLE) && (r_state != RTS) &&
                         (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

        case (r_state)
            IDLE: begin
                tx_idle       = 1'b1;
                w_to_cnt_next = '0;
                if (wr_ps2) begin
                    w_sr_next      = {~^din, din};
                    w_err_next     = 1'b0;
                    w_inh_cnt_next = '0;
                    w_state_next   = RTS;
                end
            end
            RTS: begin
                ps2c_oe       = 1'b1;
                ps2d_oe       = 1'b1;
                w_to_cnt_next = '0;
                if (r_inh_cnt == IW'(INHIBIT_CYCLES - 1))
                    w_state_next = START;
                else
                    w_inh_cnt_next = r_inh_cnt + IW'(1);
            end
            START: begin
                ps2d_oe = 1'b1;
                if (w_fall) begin
                    w_bit_cnt_next = 4'd9;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                ps2d_oe = ~r_sr[0];
                if (w_fall) begin
                    w_sr_next      = {1'b0, r_sr[8:1]};
                    w_bit_cnt_next = r_bit_cnt - 4'd1;
                    if (r_bit_cnt == 4'd1)
                        w_state_next = STOP;
                end
            end
            STOP: begin
                // Device pulls data low on its 11th clock to acknowledge.
                if (w_fall) begin
                    w_err_next   = r_ps2d_sync;
                    w_state_next = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (r_ps2c_filt && r_ps2d_sync) begin
                    tx_done      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (w_fall)
            w_to_cnt_next = '0;

        if (w_timeout) begin
            tx_done      = 1'b1;
            w_err_next   = 1'b1;
            w_state_next = IDLE;
        end

        tx_err = r_err | w_timeout;
    end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a behavioural PS/2 device that clocks the frame and answers ACK.
module tb_ps2_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_ps2;
    logic [7:0] din;
    logic       devClk, devData, glitch;
    logic       ps2cLine, ps2dLine;
    logic       ps2c_oe, ps2d_oe, tx_idle, tx_done, tx_err;

    int   errors = 0;
    int   checks = 0;
    int   doneTotal = 0;
    int   coeTotal = 0;
    logic lastErr = 1'b0;

    ps2_tx #(
        .INHIBIT_CYCLES(20),
        .FILTER_STEPS  (2),
        .TIMEOUT_CYCLES(2000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_ps2 (wr_ps2),
        .din    (din),
        .ps2c   (ps2cLine),
        .ps2d   (ps2dLine),
        .ps2c_oe(ps2c_oe),
        .ps2d_oe(ps2d_oe),
        .tx_idle(tx_idle),
        .tx_done(tx_done),
        .tx_err (tx_err)
    );

    always #5 clk = ~clk;

    // Open-collector wired-AND of host and device on both lines.
    assign ps2cLine = ~ps2c_oe & devClk & ~glitch;
    assign ps2dLine = ~ps2d_oe & devData;

    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            doneTotal++;
            lastErr = tx_err;
        end
        if (ps2c_oe === 1'b1) coeTotal++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic startXfer(input logic [7:0] b);
        @(negedge clk);
        din    = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din    = ~b;
        checks++;
        if (tx_idle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_drop: tx_idle=%b expected 0", tx_idle);
        end
    endtask

    // Device side: waits for clock release, samples start, then 10 clocks sampled on rising
    // edges, then the 11th clock with optional ACK.
    task automatic deviceXfer(input logic ack, input int abortAfter, input bit disturb,
                              output logic [10:0] frame, output bit ok);
        int guard;
        ok    = 1'b1;
        frame = '0;
        guard = 0;
        while (ps2c_oe !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            ok = 1'b0;
            return;
        end
        waitCycles(10);
        frame[0] = ps2dLine;
        for (int i = 1; i <= 10; i++) begin
            devClk = 1'b0;
            waitCycles(20);
            devClk = 1'b1;
            waitCycles(1);
            frame[i] = ps2dLine;
            if (i == abortAfter) return;
            if (disturb && i == 4) begin
                waitCycles(5);
                glitch = 1'b1;
                wr_ps2 = 1'b1;
                din    = 8'h55;
                waitCycles(1);
                glitch = 1'b0;
                wr_ps2 = 1'b0;
                waitCycles(4);
            end else begin
                waitCycles(10);
            end
            if (i == 10) devData = ack ? 1'b0 : 1'b1;
            waitCycles(9);
        end
        devClk = 1'b0;
        waitCycles(20);
        devClk = 1'b1;
        waitCycles(10);
        devData = 1'b1;
    endtask

    task automatic runFull(input string name, input logic [7:0] b, input logic ack, input bit disturb);
        logic [10:0] frame, expFrame;
        bit          ok;
        int          d0, c0, guard;
        d0 = doneTotal;
        c0 = coeTotal;
        startXfer(b);
        deviceXfer(ack, 0, disturb, frame, ok);
        guard = 0;
        while (tx_idle !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        waitCycles(2);
        expFrame = {1'b1, ~^b, b, 1'b0};
        checks++;
        if (!ok || guard >= 200) begin
            errors++;
            $display("[TB] FAIL %s complete: release_ok=%0d idle_wait=%0d expected release and idle", name, ok, guard);
        end
        checks++;
        if (frame !== expFrame) begin
            errors++;
            $display("[TB] FAIL %s frame: got %b expected %b", name, frame, expFrame);
        end
        checks++;
        if (coeTotal - c0 !== 20) begin
            errors++;
            $display("[TB] FAIL %s inhibit: ps2c_oe high %0d cycles expected 20", name, coeTotal - c0);
        end
        checks++;
        if (doneTotal - d0 !== 1) begin
            errors++;
            $display("[TB] FAIL %s done_count: got %0d expected 1", name, doneTotal - d0);
        end
        checks++;
        if (lastErr !== ~ack) begin
            errors++;
            $display("[TB] FAIL %s err_at_done: got %b expected %b", name, lastErr, ~ack);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_ps2 = 1'b0;
        din = 8'h00;
        devClk = 1'b1;
        devData = 1'b1;
        glitch = 1'b0;
        waitCycles(3);
        checks++;
        if ({ps2c_oe, ps2d_oe, tx_idle, tx_done, tx_err} !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 00100",
                     {ps2c_oe, ps2d_oe, tx_idle, tx_done, tx_err});
        end
        rst = 1'b0;
        waitCycles(5);
        checks++;
        if (tx_idle !== 1'b1 || ps2c_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: tx_idle=%b ps2c_oe=%b expected 1 0", tx_idle, ps2c_oe);
        end
    endtask

    task automatic test_timeout();
        int d0, guard, n;
        d0 = doneTotal;
        startXfer(8'h5A);
        guard = 0;
        while (ps2c_oe !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n = 0;
        while (ps2c_oe === 1'b0 && ps2d_oe === 1'b1 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 2000) begin
            errors++;
            $display("[TB] FAIL timeout_len: START lasted %0d cycles expected 2000", n);
        end
        checks++;
        if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0 || tx_idle !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_release: oe=%b%b idle=%b expected 00 1", ps2c_oe, ps2d_oe, tx_idle);
        end
        waitCycles(2);
        checks++;
        if (doneTotal - d0 !== 1 || lastErr !== 1'b1 || tx_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_status: done=%0d err_at_done=%b tx_err=%b expected 1 1 1",
                     doneTotal - d0, lastErr, tx_err);
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic [10:0] frame;
        bit          ok;
        int          d0;
        startXfer(8'hC3);
        deviceXfer(1'b1, 4, 1'b0, frame, ok);
        d0 = doneTotal;
        checks++;
        if (!ok || frame[4:1] !== 4'h3) begin
            errors++;
            $display("[TB] FAIL abort_bits: got %b expected 0011 (ok=%0d)", frame[4:1], ok);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0 || tx_idle !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_release: oe=%b%b idle=%b expected 00 1", ps2c_oe, ps2d_oe, tx_idle);
        end
        waitCycles(3);
        rst = 1'b0;
        waitCycles(50);
        checks++;
        if (doneTotal !== d0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", doneTotal - d0);
        end
        runFull("after_reset_ff", 8'hFF, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        runFull("ack_ed", 8'hED, 1'b1, 1'b0);
        runFull("ack_f4", 8'hF4, 1'b1, 1'b0);
        runFull("noack_00", 8'h00, 1'b0, 1'b0);
        checks++;
        if (tx_idle !== 1'b1 || tx_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL noack_hold: tx_idle=%b tx_err=%b expected 1 1", tx_idle, tx_err);
        end
        test_timeout();
        test_reset_mid_transfer();
        runFull("disturb_3c", 8'h3C, 1'b1, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
